// File: rtl/l2_ctrl_slave_if.sv
// TileLink-UL A/D channel bundle between the interconnect and the L2 control slave.
// Master drives A and D-ready; slave drives A-ready and the D response.
// Carries no state of its own.
interface l2_ctrl_slave_if #(
    parameter int TL_RS = 3
);
    logic [2:0]       l2_a_opcode;
    logic [2:0]       l2_a_param;
    logic [3:0]       l2_a_size;
    logic [TL_RS-1:0] l2_a_source;
    logic [3:0]       l2_a_address;
    logic [3:0]       l2_a_mask;
    logic [31:0]      l2_a_data;
    logic             l2_a_corrupt;
    logic             l2_a_valid;
    logic             l2_a_ready;

    logic [2:0]       l2_d_opcode;
    logic [1:0]       l2_d_param;
    logic [3:0]       l2_d_size;
    logic [TL_RS-1:0] l2_d_source;
    logic             l2_d_denied;
    logic [31:0]      l2_d_data;
    logic             l2_d_corrupt;
    logic             l2_d_valid;
    logic             l2_d_ready;

    modport master (
        output l2_a_opcode, l2_a_param, l2_a_size, l2_a_source, l2_a_address,
               l2_a_mask, l2_a_data, l2_a_corrupt, l2_a_valid, l2_d_ready,
        input  l2_a_ready, l2_d_opcode, l2_d_param, l2_d_size, l2_d_source,
               l2_d_denied, l2_d_data, l2_d_corrupt, l2_d_valid
    );

    modport slave (
        input  l2_a_opcode, l2_a_param, l2_a_size, l2_a_source, l2_a_address,
               l2_a_mask, l2_a_data, l2_a_corrupt, l2_a_valid, l2_d_ready,
        output l2_a_ready, l2_d_opcode, l2_d_param, l2_d_size, l2_d_source,
               l2_d_denied, l2_d_data, l2_d_corrupt, l2_d_valid
    );
endinterface

// File: rtl/l2_ctrl_slave.sv
// L2 control/status TL-UL slave: config, way-enable, flush address and a flush request engine.
// Latency: D response registered one cycle after A accept; one outstanding response.
// Backpressure: a_ready is low while a response waits for d_ready.
module l2_ctrl_slave #(
    parameter int          TL_RS     = 3,
    parameter int          WAYS      = 4,
    parameter int          FA_W      = 32,
    parameter logic [31:0] CFG_VALUE = 32'h07090401
) (
    input  logic            l2_clock_i,
    input  logic            l2_reset_i,
    l2_ctrl_slave_if.slave  tl,
    output logic [WAYS-1:0] way_enable_o,
    output logic            flush_req_o,
    output logic [FA_W-1:0] flush_addr_o,
    input  logic            flush_ack_i,
    input  logic            flush_done_i,
    output logic            flush_irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

    state_e           state_q, state_d;
    logic [WAYS-1:0]  way_en_q, way_en_d;
    logic [FA_W-1:0]  faddr_q, faddr_d;
    logic [FA_W-1:0]  flat_q, flat_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;

    logic             d_valid_q, d_valid_d;
    logic [2:0]       d_opcode_q, d_opcode_d;
    logic [3:0]       d_size_q, d_size_d;
    logic [TL_RS-1:0] d_source_q, d_source_d;
    logic             d_denied_q, d_denied_d;
    logic [31:0]      d_data_q, d_data_d;

    logic             accept, is_get, is_put, busy, start_bit, deny, wr_ok;
    logic [1:0]       reg_sel;
    logic [31:0]      bmask, rdata, old_val, merged;
    logic             unused_ok;

    assign unused_ok = ^{tl.l2_a_param, tl.l2_a_address[1:0]};

    // Decode the A beat: acceptance, deny rules, read mux and byte-lane merge.
    always_comb begin
        accept    = tl.l2_a_valid && !d_valid_q;
        is_get    = (tl.l2_a_opcode == 3'd4);
        is_put    = (tl.l2_a_opcode == 3'd0) || (tl.l2_a_opcode == 3'd1);
        busy      = (state_q != ST_IDLE);
        reg_sel   = tl.l2_a_address[3:2];
        start_bit = tl.l2_a_mask[0] && tl.l2_a_data[0];
        deny      = (!is_get && !is_put) || (tl.l2_a_size != 4'd2) ||
                    (is_put && (tl.l2_a_corrupt || (reg_sel == 2'd0) ||
                                ((reg_sel == 2'd2) && busy) ||
                                ((reg_sel == 2'd3) && start_bit && busy)));
        wr_ok     = accept && is_put && !deny;
        bmask     = {{8{tl.l2_a_mask[3]}}, {8{tl.l2_a_mask[2]}},
                     {8{tl.l2_a_mask[1]}}, {8{tl.l2_a_mask[0]}}};
        case (reg_sel)
            2'd0:    rdata = CFG_VALUE;
            2'd1:    rdata = 32'(way_en_q);
            2'd2:    rdata = 32'(faddr_q);
            default: rdata = {29'd0, irq_en_q, done_q, busy};
        endcase
        old_val = (reg_sel == 2'd1) ? 32'(way_en_q) : 32'(faddr_q);
        merged  = (old_val & ~bmask) | (tl.l2_a_data & bmask);
    end

    // Next state for the response slot, registers and flush FSM; DONE set is applied last so it wins.
    always_comb begin
        state_d    = state_q;
        way_en_d   = way_en_q;
        faddr_d    = faddr_q;
        flat_d     = flat_q;
        done_d     = done_q;
        irq_en_d   = irq_en_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_denied_d = d_denied_q;
        d_data_d   = d_data_q;

        if (accept) begin
            d_valid_d  = 1'b1;
            d_opcode_d = is_get ? 3'd1 : 3'd0;
            d_size_d   = tl.l2_a_size;
            d_source_d = tl.l2_a_source;
            d_denied_d = deny;
            d_data_d   = (is_get && !deny) ? rdata : 32'd0;
        end else if (d_valid_q && tl.l2_d_ready) begin
            d_valid_d  = 1'b0;
        end

        if (wr_ok) begin
            case (reg_sel)
                2'd1: way_en_d = merged[WAYS-1:0];
                2'd2: faddr_d  = merged[FA_W-1:0];
                2'd3: begin
                    if (tl.l2_a_mask[0]) begin
                        irq_en_d = tl.l2_a_data[2];
                        if (tl.l2_a_data[1]) done_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ok && (reg_sel == 2'd3) && start_bit) begin
                    state_d = ST_REQ;
                    flat_d  = faddr_q;
                end
            end
            ST_REQ:  if (flush_ack_i) state_d = ST_WAIT;
            ST_WAIT: begin
                if (flush_done_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also discards any pending response.
    always_ff @(posedge l2_clock_i or posedge l2_reset_i) begin
        if (l2_reset_i) begin
            state_q    <= ST_IDLE;
            way_en_q   <= '0;
            faddr_q    <= '0;
            flat_q     <= '0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            way_en_q   <= way_en_d;
            faddr_q    <= faddr_d;
            flat_q     <= flat_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_denied_q <= d_denied_d;
            d_data_q   <= d_data_d;
        end
    end

    assign tl.l2_a_ready   = !d_valid_q;
    assign tl.l2_d_valid   = d_valid_q;
    assign tl.l2_d_opcode  = d_opcode_q;
    assign tl.l2_d_param   = 2'd0;
    assign tl.l2_d_size    = d_size_q;
    assign tl.l2_d_source  = d_source_q;
    assign tl.l2_d_denied  = d_denied_q;
    assign tl.l2_d_data    = d_data_q;
    assign tl.l2_d_corrupt = 1'b0;

    assign way_enable_o = way_en_q;
    assign flush_req_o  = (state_q == ST_REQ);
    assign flush_addr_o = flat_q;
    assign flush_irq_o  = done_q && irq_en_q;
endmodule

// File: tb/tb_l2_ctrl_slave.sv
// Self-checking bench for l2_ctrl_slave: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the register map and flush engine.
module tb_l2_ctrl_slave;
    localparam int          TL_RS = 3;
    localparam int          WAYS  = 4;
    localparam int          FA_W  = 32;
    localparam logic [31:0] CFG   = 32'h07090401;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WAYS-1:0] way_en;
    logic            flush_req;
    logic [FA_W-1:0] flush_addr;
    logic            flush_ack = 1'b0;
    logic            flush_done = 1'b0;
    logic            flush_irq;

    always #5 clk = ~clk;

    l2_ctrl_slave_if #(.TL_RS(TL_RS)) tl ();

    l2_ctrl_slave #(.TL_RS(TL_RS), .WAYS(WAYS), .FA_W(FA_W), .CFG_VALUE(CFG)) dut (
        .l2_clock_i   (clk),
        .l2_reset_i   (rst),
        .tl           (tl),
        .way_enable_o (way_en),
        .flush_req_o  (flush_req),
        .flush_addr_o (flush_addr),
        .flush_ack_i  (flush_ack),
        .flush_done_i (flush_done),
        .flush_irq_o  (flush_irq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit rnd_flush = 1'b0;

    // Reference model state
    logic [31:0] m_way, m_faddr, m_lat;
    bit          m_done, m_irq, m_req, m_wait, m_dvalid;
    logic [2:0]  e_op;
    logic [3:0]  e_size;
    logic [2:0]  e_src;
    bit          e_den;
    logic [31:0] e_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_way = 0; m_faddr = 0; m_lat = 0;
        m_done = 0; m_irq = 0; m_req = 0; m_wait = 0; m_dvalid = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs presented at that edge.
    task automatic model_step();
        bit busy, get, put, st, den, clr, start_ok, set_done;
        int r;
        busy = m_req | m_wait;
        clr = 0; start_ok = 0; set_done = 0;
        if (tl.l2_a_valid && !m_dvalid) begin
            r   = int'(tl.l2_a_address[3:2]);
            get = (tl.l2_a_opcode == 3'd4);
            put = (tl.l2_a_opcode == 3'd0) || (tl.l2_a_opcode == 3'd1);
            st  = tl.l2_a_mask[0] && tl.l2_a_data[0];
            den = 0;
            if (!get && !put)                 den = 1;
            if (tl.l2_a_size != 4'd2)         den = 1;
            if (put && tl.l2_a_corrupt)       den = 1;
            if (put && r == 0)                den = 1;
            if (put && r == 2 && busy)        den = 1;
            if (put && r == 3 && st && busy)  den = 1;
            e_op = get ? 3'd1 : 3'd0; e_size = tl.l2_a_size; e_src = tl.l2_a_source;
            e_den = den; e_data = 0;
            if (get && !den) begin
                case (r)
                    0: e_data = CFG;
                    1: e_data = m_way;
                    2: e_data = m_faddr;
                    default: e_data = {29'd0, m_irq, m_done, busy};
                endcase
            end
            if (put && !den) begin
                if (r == 1) m_way = put_bytes(m_way, tl.l2_a_data, tl.l2_a_mask) & 32'hF;
                if (r == 2) m_faddr = put_bytes(m_faddr, tl.l2_a_data, tl.l2_a_mask);
                if (r == 3 && tl.l2_a_mask[0]) begin
                    m_irq = tl.l2_a_data[2]; clr = tl.l2_a_data[1]; start_ok = tl.l2_a_data[0];
                end
            end
            m_dvalid = 1;
        end else if (m_dvalid && tl.l2_d_ready) begin
            m_dvalid = 0;
        end
        if (m_wait) begin
            if (flush_done) begin m_wait = 0; set_done = 1; end
        end else if (m_req) begin
            if (flush_ack) begin m_req = 0; m_wait = 1; end
        end else if (start_ok) begin
            m_req = 1; m_lat = m_faddr;
        end
        if (set_done) m_done = 1;
        else if (clr) m_done = 0;
    endtask

    task automatic check_outputs();
        check_eq("a_ready", tl.l2_a_ready, !m_dvalid);
        check_eq("d_valid", tl.l2_d_valid, m_dvalid);
        check_eq("way_en", way_en, m_way);
        check_eq("flush_req", flush_req, m_req);
        check_eq("flush_addr", flush_addr, m_lat);
        check_eq("flush_irq", flush_irq, m_done & m_irq);
    endtask

    task automatic check_d(input string tag);
        check_eq({tag, "_opcode"}, tl.l2_d_opcode, e_op);
        check_eq({tag, "_size"}, tl.l2_d_size, e_size);
        check_eq({tag, "_source"}, tl.l2_d_source, e_src);
        check_eq({tag, "_denied"}, tl.l2_d_denied, e_den);
        check_eq({tag, "_data"}, tl.l2_d_data, e_data);
        check_eq({tag, "_param"}, tl.l2_d_param, 0);
        check_eq({tag, "_corrupt"}, tl.l2_d_corrupt, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic tick();
        if (rnd_flush) begin
            flush_ack  = ($urandom_range(0, 2) == 0);
            flush_done = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        @(negedge clk);
        model_step();
        check_outputs();
        flush_ack = 0; flush_done = 0;
    endtask

    task automatic txn(input logic [2:0] op, input logic [3:0] sz, input logic [2:0] src,
                       input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic cor, input int hold, output logic [31:0] rd, output logic den);
        tl.l2_a_opcode = op; tl.l2_a_param = 0; tl.l2_a_size = sz; tl.l2_a_source = src;
        tl.l2_a_address = addr; tl.l2_a_mask = mask; tl.l2_a_data = data; tl.l2_a_corrupt = cor;
        tl.l2_a_valid = 1;
        tick();
        tl.l2_a_valid = 0;
        rd = tl.l2_d_data; den = tl.l2_d_denied;
        check_d("resp");
        for (int i = 0; i < hold; i++) begin
            tick();
            check_d("hold");
        end
        tl.l2_d_ready = 1;
        tick();
        tl.l2_d_ready = 0;
    endtask

    task automatic put_w(input logic [3:0] addr, input logic [31:0] data, output logic den);
        logic [31:0] rd;
        txn(3'd0, 4'd2, 3'd1, addr, 4'hF, data, 1'b0, 0, rd, den);
    endtask

    task automatic get_r(input logic [3:0] addr, output logic [31:0] rd);
        logic den;
        txn(3'd4, 4'd2, 3'd2, addr, 4'hF, 32'd0, 1'b0, 0, rd, den);
    endtask

    initial begin
        logic [31:0] rd;
        logic        den;
        logic [2:0]  op;
        logic [3:0]  sz, addr;
        logic [31:0] data;

        tl.l2_a_valid = 0; tl.l2_a_opcode = 0; tl.l2_a_param = 0; tl.l2_a_size = 0;
        tl.l2_a_source = 0; tl.l2_a_address = 0; tl.l2_a_mask = 0; tl.l2_a_data = 0;
        tl.l2_a_corrupt = 0; tl.l2_d_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        check_eq("rst_d_valid", tl.l2_d_valid, 0);
        check_eq("rst_a_ready", tl.l2_a_ready, 1);
        check_eq("rst_way_en", way_en, 0);
        check_eq("rst_req", flush_req, 0);
        check_eq("rst_irq", flush_irq, 0);
        check_eq("rst_faddr", flush_addr, 0);
        check_eq("rst_d_data", tl.l2_d_data, 0);
        check_eq("rst_d_opcode", tl.l2_d_opcode, 0);
        check_eq("rst_d_source", tl.l2_d_source, 0);

        // CONFIG read
        txn(3'd4, 4'd2, 3'd5, 4'h0, 4'hF, 32'd0, 1'b0, 0, rd, den);
        check_eq("cfg_data", rd, 32'h07090401);
        check_eq("cfg_den", den, 0);

        // Partial write of way-enable
        txn(3'd1, 4'd2, 3'd3, 4'h4, 4'b0001, 32'hFF, 1'b0, 0, rd, den);
        check_eq("way_put_den", den, 0);
        check_eq("way_en_f", way_en, 4'hF);
        get_r(4'h4, rd);
        check_eq("way_read", rd, 32'h0000000F);

        // Flush handshake
        put_w(4'h8, 32'h8000_1040, den);
        put_w(4'hC, 32'h1, den);
        check_eq("start_den", den, 0);
        check_eq("req_up", flush_req, 1);
        check_eq("req_addr", flush_addr, 32'h8000_1040);
        repeat (3) tick();
        check_eq("req_held", flush_req, 1);
        flush_ack = 1;
        tick();
        check_eq("req_dropped", flush_req, 0);
        get_r(4'hC, rd);
        check_eq("ctrl_busy", rd, 32'h1);
        put_w(4'h8, 32'h1234_5678, den);
        check_eq("faddr_busy_den", den, 1);
        put_w(4'hC, 32'h1, den);
        check_eq("start_busy_den", den, 1);
        check_eq("faddr_kept", flush_addr, 32'h8000_1040);
        flush_done = 1;
        tick();
        get_r(4'hC, rd);
        check_eq("ctrl_done", rd, 32'h2);

        // Interrupt and DONE clear, then clear coinciding with done
        put_w(4'hC, 32'h6, den);
        check_eq("irq_clr0", flush_irq, 0);
        put_w(4'hC, 32'h5, den);
        flush_ack = 1; tick();
        flush_done = 1; tick();
        check_eq("irq_up", flush_irq, 1);
        put_w(4'hC, 32'h6, den);
        check_eq("irq_cleared", flush_irq, 0);
        put_w(4'hC, 32'h5, den);
        flush_ack = 1; tick();
        flush_done = 1;
        put_w(4'hC, 32'h6, den);
        get_r(4'hC, rd);
        check_eq("done_set_wins", rd, 32'h6);

        // START write in the same cycle as done is denied
        put_w(4'hC, 32'h6, den);
        put_w(4'hC, 32'h5, den);
        flush_ack = 1; tick();
        flush_done = 1;
        put_w(4'hC, 32'h5, den);
        check_eq("start_at_done_den", den, 1);
        get_r(4'hC, rd);
        check_eq("ctrl_after_race", rd, 32'h6);

        // Denied reads and D backpressure
        txn(3'd4, 4'd3, 3'd4, 4'h0, 4'hF, 32'd0, 1'b0, 0, rd, den);
        check_eq("size3_den", den, 1);
        txn(3'd2, 4'd2, 3'd6, 4'h4, 4'hF, 32'd0, 1'b0, 5, rd, den);
        check_eq("op2_den", den, 1);
        txn(3'd4, 4'd2, 3'd7, 4'h4, 4'hF, 32'd0, 1'b0, 5, rd, den);
        check_eq("hold_data", rd, 32'hF);

        // Reset asserted in REQ with a response pending
        put_w(4'hC, 32'h6, den);
        tl.l2_a_opcode = 0; tl.l2_a_size = 2; tl.l2_a_address = 4'hC; tl.l2_a_mask = 4'hF;
        tl.l2_a_data = 32'h1; tl.l2_a_corrupt = 0; tl.l2_a_valid = 1;
        tick();
        tl.l2_a_valid = 0;
        check_eq("pre_rst_req", flush_req, 1);
        check_eq("pre_rst_dvalid", tl.l2_d_valid, 1);
        #2 rst = 1;
        #1;
        check_eq("rst_req_async", flush_req, 0);
        check_eq("rst_dvalid_async", tl.l2_d_valid, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_outputs();
        check_eq("post_rst_way", way_en, 0);

        // Randomized traffic with random ack/done activity
        rnd_flush = 1;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 3'd0;
                3, 4:    op = 3'd1;
                5, 6, 7: op = 3'd4;
                default: op = 3'($urandom_range(2, 7));
            endcase
            sz   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
            addr = 4'($urandom_range(0, 15));
            data = $urandom;
            if (addr[3:2] == 2'd3 && $urandom_range(0, 1) == 1) data = 32'($urandom_range(0, 7));
            txn(op, sz, 3'($urandom_range(0, 7)), addr, 4'($urandom_range(0, 15)), data,
                1'($urandom_range(0, 9) == 0), $urandom_range(0, 3), rd, den);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_flush = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
